pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter stage sitting directly downstream of the controller FSM; consumes its pcAdd/pcJump/pcBranch strobes, flagOp, immediate and fetchPhase.
- Holds the architectural PC that addresses instruction memory.
- Evaluates the 4-bit condition code against the PSR flags and redirects the PC on taken jumps and branches.
- Supplies the link value (PC+1) that the register-file write bus uses for JAL, plus taken-status, retired-instruction count and a sticky control-error flag.

Parameters:
- WIDTH, 16, datapath width; width of jumpTarget and pcLink.
- ADDR_WIDTH, 16, PC width (ADDR_WIDTH ≤ WIDTH); all PC arithmetic is modulo 2^ADDR_WIDTH.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- fetchPhase  in  1  Controller is in FETCH; the PC must be stable.
- pcAdd  in  1  Advance the PC by 1.
- pcJump  in  1  Conditional absolute jump to jumpTarget.
- pcBranch  in  1  Conditional PC-relative branch by immediate.
- flagOp  in  4  Condition code.
- immediate  in  8  Signed two's-complement branch displacement.
- jumpTarget  in  WIDTH  Register-A value used as the jump destination.
- flags  in  5  PSR flags {N,Z,F,L,C}, with N in bit 4 and C in bit 0.
- pc  out  ADDR_WIDTH  Current PC, registered.
- pcLink  out  WIDTH  Combinational: zero-extended (pc+1) mod 2^ADDR_WIDTH.
- condTrue  out  1  Combinational result of flagOp evaluated against flags.
- takenLast  out  1  Registered: 1 if the most recent pcJump/pcBranch was taken.
- retiredCount  out  CNT_WIDTH  Number of accepted PC updates.
- ctrlError  out  1  Sticky illegal-strobe-combination flag.

Behaviour:
- Reset: when reset=1 at a clock edge: pc=RESET_PC, takenLast=0, retiredCount=0, ctrlError=0. Reset overrides all strobes in the same cycle, including mid-redirect.
- Condition codes (flagOp → condTrue):
  - 0000: Z
  - 0001: !Z
  - 0010: C
  - 0011: !C
  - 0100: L
  - 0101: !L
  - 0110: N
  - 0111: !N
  - 1000: F
  - 1001: !F
  - 1010: !L&!Z
  - 1011: L|Z
  - 1100: !N&!Z
  - 1101: N|Z
  - 1110 and 1111: always 1. 1111 is the unconditional code issued for JAL.
- Legal update: exactly one of pcAdd/pcJump/pcBranch is 1 and fetchPhase=0. The strobe is applied at the clock edge:
  - pcAdd: pc ← pc+1.
  - pcJump, condTrue=1: pc ← jumpTarget[ADDR_WIDTH-1:0]; takenLast ← 1.
  - pcJump, condTrue=0: pc ← pc+1; takenLast ← 0.
  - pcBranch, condTrue=1: pc ← pc + sign-extend(immediate). Displacement is relative to the current pc (the branch's own address). takenLast ← 1.
  - pcBranch, condTrue=0: pc ← pc+1; takenLast ← 0.
  - In every legal case, retiredCount ← retiredCount+1.
- Wrap-around:
  - All pc arithmetic wraps modulo 2^ADDR_WIDTH, e.g. 0xFFFF+1 = 0x0000, and 0x0002 + 0xFC = 0xFFFE.
  - retiredCount wraps from all-ones to 0.
- Illegal update: two or more strobes high, or any strobe high while fetchPhase=1. Then ctrlError ← 1, and pc, takenLast and retiredCount hold. ctrlError clears only on reset.
- Idle: no strobe high → all state holds.
- Flag timing: flags and flagOp are sampled combinationally in the same cycle as the strobe; there is no internal flag pipeline.
- Latency:
  - The new pc is visible on the cycle after the strobe.
  - pcLink tracks pc combinationally. In the JAL sequence the link register is therefore written with the pre-increment pc+1 in the same cycle that pcAdd is asserted.
- No combinational path from pc strobes to pc.

Test Plan:
- Reset, then pcAdd for 3 cycles → pc 0x0000→0x0001→0x0002→0x0003; retiredCount=3; pcLink=0x0004.
- pc=0x0010, pcBranch=1, immediate=0xFC, flagOp=0000, flags Z=1 → pc=0x000C, takenLast=1. Repeat with Z=0 → pc=0x000D, takenLast=0.
- pc=0x0020, pcJump=1, flagOp=1111, jumpTarget=0x1234 → pc=0x1234, takenLast=1. Same with flagOp=1100, N=1 → pc=0x0021, takenLast=0.
- pc=0xFFFF, pcAdd → pc=0x0000. pc=0x0001, branch immediate=0x80 taken → pc=0xFF81.
- pcAdd and pcJump both high (or pcAdd with fetchPhase=1) → pc and retiredCount unchanged, ctrlError=1 and held through later legal updates until reset.
- Assert reset in the same cycle as a taken pcJump → pc=RESET_PC and all counters/flags cleared.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage behind the controller FSM.
//   Holds the architectural PC. It advances the PC by one, or redirects it on
//   taken absolute jumps and PC-relative branches. It also evaluates the
//   condition code against the PSR flags, and supplies the JAL link value,
//   taken status, a retired-update count and a sticky control-error flag.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   fetchPhase    controller in FETCH; the PC must not move
//   pcAdd         advance PC by 1
//   pcJump        conditional absolute jump to jumpTarget
//   pcBranch      conditional branch by sign-extended immediate
//   flagOp        4-bit condition code
//   immediate     signed 8-bit branch displacement
//   jumpTarget    jump destination (low ADDR_WIDTH bits used)
//   flags         PSR flags {N,Z,F,L,C}
//   pc            registered program counter
//   pcLink        zero-extended pc+1 (combinational)
//   condTrue      flagOp evaluated against flags (combinational)
//   takenLast     outcome of the most recent jump/branch
//   retiredCount  number of accepted PC updates (wraps)
//   ctrlError     sticky illegal strobe combination, cleared by reset
module pc_unit #(
  parameter int                    WIDTH      = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetchPhase,
  input  logic                  pcAdd,
  input  logic                  pcJump,
  input  logic                  pcBranch,
  input  logic [3:0]            flagOp,
  input  logic [7:0]            immediate,
  input  logic [WIDTH-1:0]      jumpTarget,
  input  logic [4:0]            flags,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]      pcLink,
  output logic                  condTrue,
  output logic                  takenLast,
  output logic [CNT_WIDTH-1:0]  retiredCount,
  output logic                  ctrlError
);

  logic flag_n, flag_z, flag_f, flag_l, flag_c;
  assign {flag_n, flag_z, flag_f, flag_l, flag_c} = flags;

  always_comb begin
    condTrue = 1'b1;
    case (flagOp)
      4'h0: condTrue = flag_z;
      4'h1: condTrue = !flag_z;
      4'h2: condTrue = flag_c;
      4'h3: condTrue = !flag_c;
      4'h4: condTrue = flag_l;
      4'h5: condTrue = !flag_l;
      4'h6: condTrue = flag_n;
      4'h7: condTrue = !flag_n;
      4'h8: condTrue = flag_f;
      4'h9: condTrue = !flag_f;
      4'hA: condTrue = !flag_l && !flag_z;
      4'hB: condTrue = flag_l || flag_z;
      4'hC: condTrue = !flag_n && !flag_z;
      4'hD: condTrue = flag_n || flag_z;
      default: condTrue = 1'b1;
    endcase
  end

  logic [1:0]            strobe_cnt;
  logic                  any_strobe;
  logic                  legal_upd;
  logic                  illegal_upd;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] disp;
  logic [ADDR_WIDTH-1:0] pc_next;

  assign strobe_cnt  = 2'(pcAdd) + 2'(pcJump) + 2'(pcBranch);
  assign any_strobe  = pcAdd | pcJump | pcBranch;
  assign legal_upd   = (strobe_cnt == 2'd1) && !fetchPhase;
  assign illegal_upd = any_strobe && !legal_upd;

  assign pc_inc = pc + ADDR_WIDTH'(1);
  // Size cast of a signed operand sign-extends the displacement.
  assign disp   = ADDR_WIDTH'($signed(immediate));
  assign pcLink = WIDTH'(pc_inc);

  // Only meaningful when exactly one strobe is high; not-taken falls to pc+1.
  always_comb begin
    pc_next = pc_inc;
    if (pcJump && condTrue) begin
      pc_next = jumpTarget[ADDR_WIDTH-1:0];
    end else if (pcBranch && condTrue) begin
      pc_next = pc + disp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      takenLast    <= 1'b0;
      retiredCount <= '0;
      ctrlError    <= 1'b0;
    end else if (legal_upd) begin
      pc           <= pc_next;
      retiredCount <= retiredCount + CNT_WIDTH'(1);
      if (!pcAdd) begin
        takenLast <= condTrue;
      end
    end else if (illegal_upd) begin
      ctrlError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        fetchPhase;
  logic        pcAdd;
  logic        pcJump;
  logic        pcBranch;
  logic [3:0]  flagOp;
  logic [7:0]  immediate;
  logic [15:0] jumpTarget;
  logic [4:0]  flags;
  logic [15:0] pc;
  logic [15:0] pcLink;
  logic        condTrue;
  logic        takenLast;
  logic [15:0] retiredCount;
  logic        ctrlError;

  pc_unit #(
    .WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .fetchPhase(fetchPhase),
    .pcAdd(pcAdd), .pcJump(pcJump), .pcBranch(pcBranch),
    .flagOp(flagOp), .immediate(immediate), .jumpTarget(jumpTarget),
    .flags(flags), .pc(pc), .pcLink(pcLink), .condTrue(condTrue),
    .takenLast(takenLast), .retiredCount(retiredCount), .ctrlError(ctrlError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fetch, add, jump, br;
    logic [3:0] op;
    logic [7:0] imm;
    logic [15:0] tgt;
    logic [4:0] fl;
  } stim_t;

  // packed {pc, takenLast, retiredCount, ctrlError}
  logic [33:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic        m_taken;
  logic [15:0] m_cnt;
  logic        m_err;

  function automatic logic model_cond(input logic [3:0] op, input logic [4:0] fl);
    logic n, z, f, l, c;
    n = fl[4]; z = fl[3]; f = fl[2]; l = fl[1]; c = fl[0];
    case (op)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return c;
      4'd3:  return ~c;
      4'd4:  return l;
      4'd5:  return ~l;
      4'd6:  return n;
      4'd7:  return ~n;
      4'd8:  return f;
      4'd9:  return ~f;
      4'd10: return ~(l | z);
      4'd11: return l | z;
      4'd12: return ~(n | z);
      4'd13: return n | z;
      default: return 1'b1;
    endcase
  endfunction

  function automatic stim_t mk(input logic rst, input logic fetch, input logic add,
                               input logic jump, input logic br, input logic [3:0] op,
                               input logic [7:0] imm, input logic [15:0] tgt,
                               input logic [4:0] fl);
    stim_t s;
    s.rst = rst; s.fetch = fetch; s.add = add; s.jump = jump; s.br = br;
    s.op = op; s.imm = imm; s.tgt = tgt; s.fl = fl;
    return s;
  endfunction

  // Drives one clock of stimulus, advances the reference model and queues
  // the state expected just after the edge.
  task automatic cycle(input stim_t s);
    int n;
    logic c;
    @(negedge clk);
    reset = s.rst; fetchPhase = s.fetch;
    pcAdd = s.add; pcJump = s.jump; pcBranch = s.br;
    flagOp = s.op; immediate = s.imm; jumpTarget = s.tgt; flags = s.fl;
    n = int'(s.add) + int'(s.jump) + int'(s.br);
    if (s.rst) begin
      m_pc = 16'h0000; m_taken = 1'b0; m_cnt = 16'h0000; m_err = 1'b0;
    end else if (n == 0) begin
      m_pc = m_pc;
    end else if (n > 1 || s.fetch) begin
      m_err = 1'b1;
    end else begin
      m_cnt = m_cnt + 16'd1;
      if (s.add) begin
        m_pc = m_pc + 16'd1;
      end else begin
        c = model_cond(s.op, s.fl);
        m_taken = c;
        if (!c)         m_pc = m_pc + 16'd1;
        else if (s.jump) m_pc = s.tgt;
        else            m_pc = m_pc + {{8{s.imm[7]}}, s.imm};
      end
    end
    exp_q.push_back({m_pc, m_taken, m_cnt, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    logic [33:0] e, o;
    st.push_back(mk(1, 0, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(1, 0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    foreach (st[i]) begin
      cycle(st[i]);
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_add();
    logic [33:0] e, o;
    for (int i = 0; i < 3; i++) begin
      cycle(mk(0, 0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL add[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
    checks++;
    if (pc !== 16'h0003 || retiredCount !== 16'd3 || pcLink !== 16'h0004) begin
      errors++;
      $display("FAIL add_final got pc=%h cnt=%0d link=%h want pc=0003 cnt=3 link=0004",
               pc, retiredCount, pcLink);
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    logic [33:0] e, o;
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h0010, 5'h00));
    st.push_back(mk(0, 0, 0, 0, 1, 4'h0, 8'hFC, 16'h0000, 5'b01000));
    st.push_back(mk(0, 0, 0, 0, 1, 4'h0, 8'hFC, 16'h0000, 5'b00000));
    st.push_back(mk(0, 0, 0, 0, 1, 4'hA, 8'h05, 16'h0000, 5'b00000));
    st.push_back(mk(0, 0, 0, 0, 1, 4'hB, 8'h7F, 16'h0000, 5'b00000));
    foreach (st[i]) begin
      cycle(st[i]);
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_jump();
    stim_t st[$];
    logic [33:0] e, o;
    st.push_back(mk(0, 0, 0, 1, 0, 4'hE, 8'h00, 16'h0020, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h1234, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h0020, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hC, 8'h00, 16'h1234, 5'b10000));
    st.push_back(mk(0, 0, 0, 1, 0, 4'h3, 8'h00, 16'hBEEF, 5'b00000));
    st.push_back(mk(0, 0, 0, 0, 0, 4'hF, 8'h00, 16'h0000, 5'h00));
    foreach (st[i]) begin
      cycle(st[i]);
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    logic [33:0] e, o;
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'hFFFF, 5'h00));
    st.push_back(mk(0, 0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h0001, 5'h00));
    st.push_back(mk(0, 0, 0, 0, 1, 4'hE, 8'h80, 16'h0000, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h0002, 5'h00));
    st.push_back(mk(0, 0, 0, 0, 1, 4'hF, 8'hFC, 16'h0000, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'hFFF0, 5'h00));
    st.push_back(mk(0, 0, 0, 0, 1, 4'hF, 8'h7F, 16'h0000, 5'h00));
    foreach (st[i]) begin
      cycle(st[i]);
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_cond();
    logic want;
    @(negedge clk);
    pcAdd = 1'b0; pcJump = 1'b0; pcBranch = 1'b0; reset = 1'b0; fetchPhase = 1'b0;
    for (int op = 0; op < 16; op++) begin
      for (int fl = 0; fl < 32; fl++) begin
        flagOp = 4'(op);
        flags = 5'(fl);
        #0.1;
        want = model_cond(4'(op), 5'(fl));
        checks++;
        if (condTrue !== want) begin
          errors++;
          $display("FAIL cond op=%h flags=%b got %b want %b", op[3:0], fl[4:0], condTrue, want);
        end
      end
    end
  endtask

  task automatic test_error();
    stim_t st[$];
    logic [33:0] e, o;
    st.push_back(mk(0, 0, 1, 1, 0, 4'hF, 8'h00, 16'h4444, 5'h00));
    st.push_back(mk(0, 1, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(0, 0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 1, 4'hF, 8'h10, 16'h5555, 5'h00));
    st.push_back(mk(0, 1, 0, 1, 0, 4'hF, 8'h00, 16'h6666, 5'h00));
    st.push_back(mk(0, 0, 1, 1, 1, 4'hF, 8'h00, 16'h7777, 5'h00));
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h0100, 5'h00));
    st.push_back(mk(0, 1, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(1, 0, 0, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    foreach (st[i]) begin
      cycle(st[i]);
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL error[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [33:0] e, o;
    st.push_back(mk(0, 0, 0, 1, 0, 4'hF, 8'h00, 16'h0300, 5'h00));
    st.push_back(mk(0, 0, 0, 0, 1, 4'h1, 8'h02, 16'h0000, 5'b00000));
    st.push_back(mk(0, 0, 1, 1, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(1, 0, 0, 1, 0, 4'hF, 8'h00, 16'h9ABC, 5'h00));
    st.push_back(mk(0, 0, 1, 0, 0, 4'h0, 8'h00, 16'h0000, 5'h00));
    st.push_back(mk(1, 0, 0, 0, 1, 4'hF, 8'h40, 16'h0000, 5'h00));
    foreach (st[i]) begin
      cycle(st[i]);
      e = exp_q.pop_front();
      o = {pc, takenLast, retiredCount, ctrlError};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b[%0d] got pc=%h tk=%b cnt=%h err=%b want pc=%h tk=%b cnt=%h err=%b",
                 i, o[33:18], o[17], o[16:1], o[0], e[33:18], e[17], e[16:1], e[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; fetchPhase = 1'b0; pcAdd = 1'b0; pcJump = 1'b0; pcBranch = 1'b0;
    flagOp = 4'h0; immediate = 8'h00; jumpTarget = 16'h0000; flags = 5'h00;
    m_pc = 16'h0000; m_taken = 1'b0; m_cnt = 16'h0000; m_err = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_jump();
    test_wrap();
    test_cond();
    test_error();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
